// File: rtl/aoc_pkg.sv
// Shared definitions for the list sorter and the similarity scorer:
// default widths and the scorer FSM state encoding.
package aoc_pkg;

    localparam int SCORER_DATA_W = 32;
    localparam int SCORER_LEN_W  = 16;
    localparam int SCORER_ACC_W  = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        STEP = 2'd2,
        DONE = 2'd3
    } scorer_state_t;

endpackage

// File: rtl/similarity_scorer_mac.sv
// Registered multiply-accumulate: acc <= acc + a*cnt when enabled, cleared on request.
// The product is the full DATA_W+LEN_W width, zero-extended into the wrapping accumulator.
module score_mac
    import aoc_pkg::*;
#(
    parameter int DATA_W = SCORER_DATA_W,
    parameter int LEN_W  = SCORER_LEN_W,
    parameter int ACC_W  = SCORER_ACC_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clear,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_a,
    input  logic [LEN_W-1:0]  i_cnt,
    output logic [ACC_W-1:0]  o_acc
);

    localparam int PROD_W = DATA_W + LEN_W;

    logic [PROD_W-1:0] w_prod;
    logic [ACC_W-1:0]  w_sum;
    logic [ACC_W-1:0]  r_acc;

    assign w_prod = {{LEN_W{1'b0}}, i_a} * {{DATA_W{1'b0}}, i_cnt};
    assign w_sum  = r_acc + ACC_W'(w_prod);
    assign o_acc  = r_acc;

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= w_sum;
        end
    end

endmodule

// File: rtl/similarity_scorer.sv
// Merge-walks two sorted list memories and scores sum(L[i] * count of R equal to L[i]).
// Every address change is followed by WAIT so STEP sees data from async or 1-cycle sync memories.
module similarity_scorer
    import aoc_pkg::*;
#(
    parameter int DATA_W = SCORER_DATA_W,
    parameter int LEN_W  = SCORER_LEN_W,
    parameter int ACC_W  = SCORER_ACC_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    input  logic [LEN_W-1:0]  length,
    output logic              done,
    output logic [ACC_W-1:0]  result,
    output logic [LEN_W-1:0]  l_addr,
    input  logic [DATA_W-1:0] l_data,
    output logic [LEN_W-1:0]  r_addr,
    input  logic [DATA_W-1:0] r_data,
    output scorer_state_t     dbg_state
);

    scorer_state_t     r_state;
    logic [LEN_W-1:0]  r_n;
    logic [LEN_W-1:0]  r_cnt;
    logic [LEN_W-1:0]  r_l_addr;
    logic [LEN_W-1:0]  r_r_addr;
    logic [DATA_W-1:0] r_prev;
    logic              r_first;
    logic              r_new_a;
    logic              r_done;
    logic [ACC_W-1:0]  r_result;

    logic              w_r_end;
    logic              w_new_run;
    logic [LEN_W-1:0]  w_cnt_eff;
    logic              w_adv_r;
    logic              w_last_l;
    logic              w_mac_clear;
    logic              w_mac_en;
    logic [ACC_W-1:0]  w_acc;

    // A new left value restarts the match count; a repeat of the previous value reuses it.
    assign w_r_end   = (r_r_addr == r_n);
    assign w_new_run = r_new_a && (r_first || (l_data != r_prev));
    assign w_cnt_eff = w_new_run ? '0 : r_cnt;
    assign w_adv_r   = !w_r_end && (r_data <= l_data);
    assign w_last_l  = (r_l_addr == (r_n - LEN_W'(1)));

    assign w_mac_clear = (r_state == IDLE) && go;
    assign w_mac_en    = (r_state == STEP) && !w_adv_r;

    score_mac #(
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk     (clk),
        .reset   (reset),
        .i_clear (w_mac_clear),
        .i_en    (w_mac_en),
        .i_a     (l_data),
        .i_cnt   (w_cnt_eff),
        .o_acc   (w_acc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_n      <= '0;
            r_cnt    <= '0;
            r_l_addr <= '0;
            r_r_addr <= '0;
            r_prev   <= '0;
            r_first  <= 1'b0;
            r_new_a  <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (go) begin
                        r_n      <= length;
                        r_l_addr <= '0;
                        r_r_addr <= '0;
                        r_cnt    <= '0;
                        r_first  <= 1'b1;
                        r_new_a  <= 1'b1;
                        r_done   <= 1'b0;
                        r_state  <= (length == '0) ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    r_state <= STEP;
                end
                STEP: begin
                    if (w_adv_r) begin
                        r_r_addr <= r_r_addr + LEN_W'(1);
                        r_cnt    <= (r_data == l_data) ? (w_cnt_eff + LEN_W'(1)) : w_cnt_eff;
                        r_new_a  <= 1'b0;
                        r_state  <= WAIT;
                    end else begin
                        r_prev  <= l_data;
                        r_cnt   <= w_cnt_eff;
                        r_new_a <= 1'b1;
                        r_first <= 1'b0;
                        if (w_last_l) begin
                            r_state <= DONE;
                        end else begin
                            r_l_addr <= r_l_addr + LEN_W'(1);
                            r_state  <= WAIT;
                        end
                    end
                end
                DONE: begin
                    r_result <= w_acc;
                    r_done   <= 1'b1;
                    r_state  <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign done      = r_done;
    assign result    = r_result;
    assign l_addr    = r_l_addr;
    assign r_addr    = r_r_addr;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_similarity_scorer.sv
// Bench for similarity_scorer: directed cases plus randomized sorted lists scored by a
// count-and-multiply reference model; memories switchable between async and sync read.
module tb_similarity_scorer;
    import aoc_pkg::*;

    localparam int DW = 32;
    localparam int LW = 16;
    localparam int AW = 64;
    localparam int MEM_D = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          go;
    logic [LW-1:0] length;
    logic          done;
    logic [AW-1:0] result;
    logic [LW-1:0] l_addr;
    logic [DW-1:0] l_data;
    logic [LW-1:0] r_addr;
    logic [DW-1:0] r_data;
    scorer_state_t dbg_state;

    always #5 clk = ~clk;

    similarity_scorer dut (
        .clk       (clk),
        .reset     (reset),
        .go        (go),
        .length    (length),
        .done      (done),
        .result    (result),
        .l_addr    (l_addr),
        .l_data    (l_data),
        .r_addr    (r_addr),
        .r_data    (r_data),
        .dbg_state (dbg_state)
    );

    // Memory models: async read or 1-cycle registered read, chosen per pass.
    logic [DW-1:0] l_mem [0:MEM_D-1];
    logic [DW-1:0] r_mem [0:MEM_D-1];
    logic [DW-1:0] l_rd, r_rd, l_q, r_q;
    bit            async_mode = 1'b0;

    assign l_rd   = (l_addr < LW'(MEM_D)) ? l_mem[l_addr[5:0]] : '0;
    assign r_rd   = (r_addr < LW'(MEM_D)) ? r_mem[r_addr[5:0]] : '0;
    assign l_data = async_mode ? l_rd : l_q;
    assign r_data = async_mode ? r_rd : r_q;

    always_ff @(posedge clk) begin
        l_q <= l_rd;
        r_q <= r_rd;
    end

    logic [DW-1:0] lq[$];
    logic [DW-1:0] rq[$];
    logic [AW-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Score straight from the definition: each left entry times its count in the right list.
    function automatic logic [AW-1:0] ref_score();
        logic [AW-1:0] acc = '0;
        for (int i = 0; i < lq.size(); i++) begin
            int c = 0;
            for (int j = 0; j < rq.size(); j++) begin
                if (rq[j] == lq[i]) c++;
            end
            acc = acc + AW'(lq[i]) * AW'(c);
        end
        return acc;
    endfunction

    task automatic load_lists();
        for (int i = 0; i < MEM_D; i++) begin
            l_mem[i] = (i < lq.size()) ? lq[i] : $urandom;
            r_mem[i] = (i < rq.size()) ? rq[i] : $urandom;
        end
    endtask

    task automatic make_sorted(input int n, input logic [DW-1:0] base, input int span);
        lq.delete();
        rq.delete();
        for (int i = 0; i < n; i++) begin
            lq.push_back(base + DW'($urandom_range(0, span)));
            rq.push_back(base + DW'($urandom_range(0, span)));
        end
        lq.sort();
        rq.sort();
    endtask

    task automatic run_pass(input string tag, input int poke_at);
        int n;
        int cyc;
        int budget;
        logic [AW-1:0] exp;
        n = lq.size();
        budget = 4 * n + 20;
        exp_q.push_back(ref_score());
        load_lists();
        @(negedge clk);
        length = LW'(n);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < budget) begin
            if (cyc == poke_at) begin
                go = 1'b1;
                length = LW'(1);
            end else begin
                go = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        go = 1'b0;
        check({tag, "_done"}, AW'(done), AW'(1));
        check({tag, "_cycles_le_4n2"}, AW'(cyc <= 4 * n + 2), AW'(1));
        exp = exp_q.pop_front();
        check({tag, "_result"}, result, exp);
    endtask

    initial begin
        reset = 1'b1;
        go = 1'b0;
        length = '0;
        repeat (3) @(negedge clk);
        check("rst_done", AW'(done), AW'(0));
        check("rst_result", result, AW'(0));
        check("rst_l_addr", AW'(l_addr), AW'(0));
        check("rst_r_addr", AW'(r_addr), AW'(0));
        check("rst_state", AW'(dbg_state), AW'(IDLE));
        reset = 1'b0;

        lq = '{1, 2, 3, 3, 3, 4};
        rq = '{3, 3, 3, 4, 5, 9};
        run_pass("t1", 0);
        check("t1_exp31", result, AW'(31));
        repeat (2) @(negedge clk);
        check("t1_done_hold", AW'(done), AW'(1));
        check("t1_result_hold", result, AW'(31));

        async_mode = 1'b1;
        run_pass("t1_async", 0);
        async_mode = 1'b0;

        lq = {};
        rq = {};
        run_pass("t2_n0", 0);
        check("t2_l_addr", AW'(l_addr), AW'(0));
        check("t2_r_addr", AW'(r_addr), AW'(0));

        lq = '{1, 2};
        rq = '{5, 6};
        run_pass("t3_nomatch", 0);
        lq = '{7, 7, 7};
        rq = '{7, 7, 7};
        run_pass("t3_run", 0);
        check("t3_exp63", result, AW'(63));

        lq = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};
        rq = '{32'hFFFF_FFFF, 32'hFFFF_FFFF};
        run_pass("t4_wide", 0);
        check("t4_exp", result, 64'h3_FFFF_FFFC);

        lq = '{1, 2, 3, 3, 3, 4};
        rq = '{3, 3, 3, 4, 5, 9};
        run_pass("t5_poke", 3);

        // Abandon a pass five cycles in, then rerun it.
        load_lists();
        @(negedge clk);
        length = LW'(6);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t6_done", AW'(done), AW'(0));
        check("t6_result", result, AW'(0));
        check("t6_l_addr", AW'(l_addr), AW'(0));
        check("t6_state", AW'(dbg_state), AW'(IDLE));
        reset = 1'b0;
        run_pass("t6_rerun", 0);

        for (int k = 0; k < 10; k++) begin
            async_mode = ($urandom_range(0, 1) == 1);
            make_sorted($urandom_range(1, 14), DW'(0), 5);
            run_pass($sformatf("rnd%0d", k), 0);
        end
        for (int k = 0; k < 3; k++) begin
            async_mode = ($urandom_range(0, 1) == 1);
            make_sorted($urandom_range(1, 10), 32'hFFFF_FFF8, 7);
            run_pass($sformatf("rnd_wide%0d", k), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
